// File: rtl/pacessor_pkg.sv
// Shared definitions for the program loader: FSM state encoding, program
// memory address width and the default core reset hold time.
package pacessor_pkg;

  localparam int PROG_ADDR_W  = 6;
  localparam int RST_HOLD_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams host bytes into program memory (big-endian words,
// byte 0 of word k at address 4k), verifies a trailing XOR checksum byte and
// then holds the processor core in reset for RST_HOLD cycles before release.
//
// Handshake: a host byte is transferred in every cycle where in_valid and
// in_ready are both high. in_ready depends only on the FSM state (LOAD or
// CHECK); in_valid without in_ready has no effect, and gaps in in_valid
// simply stall the load.
module prog_loader
  import pacessor_pkg::*;
#(
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst_master_n,
  input  logic       start,
  input  logic [3:0] len_m1,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [5:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       core_rst,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] fsm_state
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t                   state;
  state_t                   state_n;
  logic [3:0]               len_q;
  logic [PROG_ADDR_W-1:0]   cnt;
  logic [7:0]               acc;
  logic [HOLD_W-1:0]        hold_cnt;
  logic                     done_q;

  logic                     xfer;
  logic                     start_ok;
  logic                     hold_last;
  logic [PROG_ADDR_W-1:0]   last_addr;

  // Handshake, start qualification and end-of-phase decodes.
  assign in_ready  = (state == S_LOAD) || (state == S_CHECK);
  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERR));
  assign hold_last = (hold_cnt == HOLD_W'(RST_HOLD - 1));
  assign last_addr = {len_q, 2'b11};
  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_master_n) begin
    if (!rst_master_n) state <= S_IDLE;
    else               state <= state_n;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_n   = state;
    mem_we    = 1'b0;
    mem_addr  = cnt;
    mem_wdata = in_data;
    busy      = 1'b0;
    err       = 1'b0;
    core_rst  = (state != S_RUN);
    done      = done_q;
    case (state)
      S_IDLE, S_RUN: begin
        if (start_ok) state_n = S_LOAD;
      end
      S_ERR: begin
        err = 1'b1;
        if (start_ok) state_n = S_LOAD;
      end
      S_LOAD: begin
        busy   = 1'b1;
        mem_we = xfer;
        if (xfer && (cnt == last_addr)) state_n = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (xfer) state_n = (in_data == acc) ? S_HOLD : S_ERR;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (hold_last) state_n = S_RUN;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Load datapath: length latch, byte address counter and XOR accumulator.
  always_ff @(posedge clk or negedge rst_master_n) begin
    if (!rst_master_n) begin
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else if (start_ok) begin
      len_q <= len_m1;
      cnt   <= '0;
      acc   <= '0;
    end else if ((state == S_LOAD) && xfer) begin
      cnt <= cnt + 1'b1;
      acc <= acc ^ in_data;
    end
  end

  // Reset-hold timer and the one-cycle done pulse for the first RUN cycle.
  always_ff @(posedge clk or negedge rst_master_n) begin
    if (!rst_master_n) begin
      hold_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == S_HOLD) && hold_last;
      if (state != S_HOLD) hold_cnt <= '0;
      else if (!hold_last) hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule
